// File: rtl/tape_player.sv
// Cassette playback engine: streams tape bytes from RAM as pulse-width encoded bits on latch,
// one sync pulse per bit cell plus a second pulse for a '1', MSB first.
module tape_player #(
  parameter int PULSE  = 512,
  parameter int BIT_AT = 1791,
  parameter int PERIOD = 3585
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [16:0] dn_addr,
  input  logic        play,
  input  logic        motor_wr,
  input  logic        motor_d,
  input  logic        port_rd,
  output logic [16:0] ram_a,
  input  logic [7:0]  ram_q,
  output logic        latch,
  output logic        motor,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(PERIOD + BIT_AT + PULSE + 1);
  localparam logic [CW-1:0] C_PULSE   = CW'(PULSE);
  localparam logic [CW-1:0] C_BIT_AT  = CW'(BIT_AT);
  localparam logic [CW-1:0] C_WIN_END = CW'(BIT_AT + PULSE);
  localparam logic [CW-1:0] C_LAST    = CW'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [16:0] r_addr;
  logic [16:0] r_tape_len;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic        r_bitval;
  logic        r_latch;
  logic        r_motor;
  logic        r_play_d;

  logic w_dn_wr;
  logic w_mw;
  logic w_rd;
  logic w_start;
  logic w_arm_rst;
  logic w_motor_off;
  logic w_tick;
  logic w_bit_at;
  logic w_cell_end;
  logic w_byte_end;
  logic w_set;

  assign w_dn_wr     = dn_go & dn_wr;
  assign w_mw        = ce & motor_wr;
  assign w_rd        = ce & port_rd;
  assign w_start     = play & ~r_play_d & ((r_state == S_IDLE) | (r_state == S_ARMED));
  assign w_arm_rst   = w_mw & motor_d & ~r_motor;
  assign w_motor_off = w_mw & ~motor_d;
  assign w_tick      = ce & (r_state == S_PLAY) & ~w_motor_off;
  assign w_bit_at    = w_tick & (r_cnt == C_BIT_AT);
  assign w_cell_end  = w_tick & (r_cnt == C_LAST);
  assign w_byte_end  = w_cell_end & (r_bitcnt == 4'd8);
  // bitval is already updated for the cell when the data window opens (cnt > BIT_AT)
  assign w_set       = w_tick & ((r_cnt < C_PULSE) |
                                 (r_bitval & (r_cnt > C_BIT_AT) & (r_cnt <= C_WIN_END)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (dn_go)                                   w_next = S_IDLE;
    else if (w_motor_off)                        w_next = S_IDLE;
    else if (w_arm_rst && (r_state == S_IDLE))   w_next = S_ARMED;
    else if (w_start)                            w_next = S_FETCH;
    else begin
      case (r_state)
        S_ARMED: if (w_rd) w_next = S_FETCH;
        S_FETCH: w_next = S_LOAD;
        S_LOAD:  w_next = S_PLAY;
        S_PLAY:  if (w_byte_end) w_next = (r_addr == r_tape_len) ? S_END : S_FETCH;
        S_END:   w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_END);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_tape_len <= '0;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_bitval   <= 1'b0;
      r_latch    <= 1'b0;
      r_motor    <= 1'b0;
      // Held high so a play level present across reset is not seen as a new press
      r_play_d   <= 1'b1;
    end else begin
      r_play_d <= play;
      if (w_dn_wr) r_tape_len <= dn_addr;
      if (dn_go) begin
        r_addr  <= '0;
        r_latch <= 1'b0;
      end else begin
        if (w_mw) r_motor <= motor_d;

        if (w_arm_rst || w_start) begin
          r_addr   <= '0;
          r_bitcnt <= '0;
        end else if (w_tick) begin
          if (w_bit_at) begin
            r_bitval <= r_shreg[7];
            r_shreg  <= {r_shreg[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          if (w_byte_end) begin
            r_bitcnt <= '0;
            r_addr   <= r_addr + 17'd1;
          end
        end

        if (w_start || ((r_state == S_ARMED) && w_rd)) r_cnt <= '0;
        else if (w_tick) r_cnt <= w_cell_end ? '0 : r_cnt + CW'(1);

        if (r_state == S_LOAD) r_shreg <= ram_q;

        if (w_mw)       r_latch <= 1'b0;
        else if (w_set) r_latch <= 1'b1;
        else if (w_rd)  r_latch <= 1'b0;
      end
    end
  end

  assign ram_a = w_dn_wr ? dn_addr : r_addr;
  assign latch = r_latch;
  assign motor = r_motor;

endmodule
